// File: rtl/stack_alu_pkg.sv
// stack_alu_pkg: shared definitions for the stack_alu RPN front-end.
//   op_e     - opcode encoding presented on i_op
//   state_e  - handshake FSM states
//   ERR_*    - sticky error codes reported on o_err_code
package stack_alu_pkg;

    typedef enum logic [2:0] {
        OP_LIT  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_XOR  = 3'd4,
        OP_DUP  = 3'd5,
        OP_DROP = 3'd6,
        OP_SWAP = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;

endpackage

// File: rtl/stack_alu_op.sv
// stack_alu_op: combinational result of a pop-type operation.
//   i_op     - opcode latched at accept
//   i_nos    - next-on-stack, as returned by the stack
//   i_tos    - current top-of-stack register
//   o_result - new TOS; DROP and SWAP simply take NOS
module stack_alu_op
    import stack_alu_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_nos,
    input  logic [WIDTH-1:0] i_tos,
    output logic [WIDTH-1:0] o_result
);

    always_comb begin
        o_result = i_nos;
        case (i_op)
            OP_ADD:  o_result = i_nos + i_tos;
            OP_SUB:  o_result = i_nos - i_tos;
            OP_AND:  o_result = i_nos & i_tos;
            OP_XOR:  o_result = i_nos ^ i_tos;
            default: o_result = i_nos;
        endcase
    end

endmodule

// File: rtl/stack_alu.sv
// stack_alu: Reverse-Polish ALU front-end for an external circular LIFO.
// TOS is held locally; deeper entries live in the stack block, which this
// module drives directly. Depth is tracked here so over/underflow are caught
// before they reach the stack.
//   i_clk, i_rst           - clock, synchronous active-high reset
//   i_valid/o_ready        - opcode handshake (i_op, i_imm)
//   o_tos, o_depth         - top-of-stack value and live entry count (0..CAP)
//   o_err, o_err_code      - sticky error flag and first error code
//   o_stk_push/pop/data    - strobes and write data to the stack
//   i_stk_data             - stack read data, valid the cycle after a pop
//
// state   | meaning
// IDLE    | ready for an opcode
// WAIT    | pop issued last cycle; consume i_stk_data this cycle
module stack_alu
    import stack_alu_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int STACK_SIZE = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic [WIDTH-1:0]      i_imm,
    output logic [WIDTH-1:0]      o_tos,
    output logic [STACK_SIZE:0]   o_depth,
    output logic                  o_err,
    output logic [1:0]            o_err_code,
    output logic                  o_stk_push,
    output logic                  o_stk_pop,
    output logic [WIDTH-1:0]      o_stk_data,
    input  logic [WIDTH-1:0]      i_stk_data
);

    localparam int DW = STACK_SIZE + 1;
    localparam logic [DW-1:0] CAP = DW'(2**STACK_SIZE + 1);
    localparam logic [DW-1:0] ONE = DW'(1);
    localparam logic [DW-1:0] TWO = DW'(2);

    state_e             state_q, state_d;
    op_e                op_in, op_q;
    logic [WIDTH-1:0]   tos_q, result;
    logic [DW-1:0]      depth_q;
    logic               err_q;
    logic [1:0]         code_q;
    logic               accept, under, over, legal;

    assign op_in  = op_e'(i_op);
    assign accept = i_valid && (state_q == ST_IDLE);

    always_comb begin
        under = 1'b0;
        over  = 1'b0;
        case (op_in)
            OP_LIT:  over = (depth_q == CAP);
            OP_DUP: begin
                under = (depth_q == '0);
                over  = (depth_q == CAP);
            end
            OP_DROP: under = (depth_q == '0);
            default: under = (depth_q < TWO);
        endcase
    end

    assign legal = accept && !under && !over;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        o_stk_push = 1'b0;
        o_stk_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (legal) begin
                    case (op_in)
                        OP_LIT:  o_stk_push = (depth_q != '0);
                        OP_DUP:  o_stk_push = 1'b1;
                        OP_DROP: o_stk_pop  = (depth_q >= TWO);
                        OP_SWAP: begin
                            o_stk_push = 1'b1;
                            o_stk_pop  = 1'b1;
                        end
                        default: o_stk_pop  = 1'b1;
                    endcase
                end
                if (o_stk_pop) state_d = ST_WAIT;
            end
            ST_WAIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_stk_data = o_stk_push ? tos_q : '0;

    stack_alu_op #(.WIDTH(WIDTH)) u_op (
        .i_op     (op_q),
        .i_nos    (i_stk_data),
        .i_tos    (tos_q),
        .o_result (result)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tos_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            op_q    <= OP_LIT;
        end else if (state_q == ST_WAIT) begin
            tos_q <= result;
            if (op_q != OP_SWAP) depth_q <= depth_q - ONE;
        end else if (accept) begin
            if (under || over) begin
                err_q <= 1'b1;
                // first error wins; underflow outranks overflow
                if (code_q == ERR_NONE) code_q <= under ? ERR_UNDER : ERR_OVER;
            end else begin
                op_q <= op_in;
                case (op_in)
                    OP_LIT: begin
                        tos_q   <= i_imm;
                        depth_q <= depth_q + ONE;
                    end
                    OP_DUP: depth_q <= depth_q + ONE;
                    OP_DROP: begin
                        if (depth_q == ONE) begin
                            tos_q   <= '0;
                            depth_q <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_ready    = (state_q == ST_IDLE);
    assign o_tos      = tos_q;
    assign o_depth    = depth_q;
    assign o_err      = err_q;
    assign o_err_code = code_q;

endmodule

// File: tb/tb_stack_alu.sv
module tb_stack_alu;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op = 3'd0;
    logic [17:0] i_imm = '0;
    logic [17:0] o_tos;
    logic [2:0]  o_depth;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic        o_stk_push, o_stk_pop;
    logic [17:0] o_stk_data;
    logic [17:0] i_stk_data;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    stack_alu #(.WIDTH(18), .STACK_SIZE(2)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_imm      (i_imm),
        .o_tos      (o_tos),
        .o_depth    (o_depth),
        .o_err      (o_err),
        .o_err_code (o_err_code),
        .o_stk_push (o_stk_push),
        .o_stk_pop  (o_stk_pop),
        .o_stk_data (o_stk_data),
        .i_stk_data (i_stk_data)
    );

    // behavioural LIFO standing in for the external stack block
    logic [17:0] stk_mem [0:15];
    int          sp = 0;
    logic [17:0] stk_out = '0;
    assign i_stk_data = stk_out;

    always @(posedge i_clk) begin
        if (i_rst) begin
            sp      <= 0;
            stk_out <= '0;
        end else if (o_stk_push && o_stk_pop) begin
            stk_out <= (sp > 0) ? stk_mem[sp-1] : '0;
            if (sp > 0) stk_mem[sp-1] <= o_stk_data;
        end else if (o_stk_pop) begin
            stk_out <= (sp > 0) ? stk_mem[sp-1] : '0;
            if (sp > 0) sp <= sp - 1;
        end else if (o_stk_push) begin
            if (sp < 16) begin
                stk_mem[sp] <= o_stk_data;
                sp <= sp + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // drive one op, capture strobes before the accepting edge, then wait out WAIT
    task automatic apply(input logic [2:0] op, input logic [17:0] imm,
                         output logic p, output logic q, output logic [17:0] d,
                         output int waits);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_op    = op;
        i_imm   = imm;
        #1;
        p = o_stk_push;
        q = o_stk_pop;
        d = o_stk_data;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        waits = 0;
        while (!o_ready && waits < 4) begin
            @(posedge i_clk);
            #1;
            waits++;
        end
        if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  op;
        logic [17:0] imm;
        logic        push;
        logic        pop;
        logic [17:0] data;
        logic [17:0] tos;
        logic [2:0]  depth;
        logic        err;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [2:0] op, input logic [17:0] imm,
                       input logic push, input logic pop, input logic [17:0] data,
                       input logic [17:0] tos, input logic [2:0] depth,
                       input logic err, input logic [1:0] code);
        vec_t v;
        v.rst = rst; v.op = op; v.imm = imm; v.push = push; v.pop = pop;
        v.data = data; v.tos = tos; v.depth = depth; v.err = err; v.code = code;
        vecs.push_back(v);
    endtask

    initial begin
        logic        p, q;
        logic [17:0] d;
        int          w;
        logic [17:0] m[$];
        logic        m_err;
        logic [1:0]  m_code;

        // LIT 3, LIT 5, ADD
        add(1, 0, 3,   0, 0, 0,   3, 1, 0, 0);
        add(0, 0, 5,   1, 0, 3,   5, 2, 0, 0);
        add(0, 1, 0,   0, 1, 0,   8, 1, 0, 0);
        // LIT 2, LIT 7, SUB wraps
        add(1, 0, 2,   0, 0, 0,   2, 1, 0, 0);
        add(0, 0, 7,   1, 0, 2,   7, 2, 0, 0);
        add(0, 2, 0,   0, 1, 0,   18'h3FFFB, 1, 0, 0);
        // LIT 1, LIT 2, SWAP, DROP
        add(1, 0, 1,   0, 0, 0,   1, 1, 0, 0);
        add(0, 0, 2,   1, 0, 1,   2, 2, 0, 0);
        add(0, 7, 0,   1, 1, 2,   1, 2, 0, 0);
        add(0, 6, 0,   0, 1, 0,   2, 1, 0, 0);
        // six LITs: overflow on the sixth, DUP at full also overflows
        add(1, 0, 1,   0, 0, 0,   1, 1, 0, 0);
        add(0, 0, 2,   1, 0, 1,   2, 2, 0, 0);
        add(0, 0, 3,   1, 0, 2,   3, 3, 0, 0);
        add(0, 0, 4,   1, 0, 3,   4, 4, 0, 0);
        add(0, 0, 5,   1, 0, 4,   5, 5, 0, 0);
        add(0, 0, 6,   0, 0, 0,   5, 5, 1, 2);
        add(0, 5, 0,   0, 0, 0,   5, 5, 1, 2);
        // ADD on empty stack underflows; code sticks through later ops
        add(1, 1, 0,   0, 0, 0,   0, 0, 1, 1);
        add(0, 0, 9,   0, 0, 0,   9, 1, 1, 1);
        // DUP, AND, XOR, DROP to empty, then underflows
        add(1, 0, 18'h0F0F0, 0, 0, 0,          18'h0F0F0, 1, 0, 0);
        add(0, 5, 0,         1, 0, 18'h0F0F0,  18'h0F0F0, 2, 0, 0);
        add(0, 0, 18'h3C3C3, 1, 0, 18'h0F0F0,  18'h3C3C3, 3, 0, 0);
        add(0, 3, 0,         0, 1, 0,          18'h0C0C0, 2, 0, 0);
        add(0, 4, 0,         0, 1, 0,          18'h03030, 1, 0, 0);
        add(0, 6, 0,         0, 0, 0,          0, 0, 0, 0);
        add(0, 6, 0,         0, 0, 0,          0, 0, 1, 1);
        add(0, 5, 0,         0, 0, 0,          0, 0, 1, 1);

        do_reset();
        chk("rst_tos",   32'(o_tos), 0);
        chk("rst_depth", 32'(o_depth), 0);
        chk("rst_err",   32'(o_err), 0);
        chk("rst_code",  32'(o_err_code), 0);
        chk("rst_ready", 32'(o_ready), 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i].op, vecs[i].imm, p, q, d, w);
            chk($sformatf("v%0d_push", i), 32'(p), 32'(vecs[i].push));
            chk($sformatf("v%0d_pop", i),  32'(q), 32'(vecs[i].pop));
            if (vecs[i].push) chk($sformatf("v%0d_data", i), 32'(d), 32'(vecs[i].data));
            chk($sformatf("v%0d_wait", i),  w, 32'(vecs[i].pop));
            chk($sformatf("v%0d_tos", i),   32'(o_tos), 32'(vecs[i].tos));
            chk($sformatf("v%0d_depth", i), 32'(o_depth), 32'(vecs[i].depth));
            chk($sformatf("v%0d_err", i),   32'(o_err), 32'(vecs[i].err));
            chk($sformatf("v%0d_code", i),  32'(o_err_code), 32'(vecs[i].code));
        end

        // i_valid held through WAIT must not be accepted
        do_reset();
        apply(0, 10, p, q, d, w);
        apply(0, 20, p, q, d, w);
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'd1;
        @(posedge i_clk); #1;
        chk("hold_ready", 32'(o_ready), 0);
        i_op = 3'd0; i_imm = 18'd99;
        #1;
        chk("hold_push", 32'(o_stk_push), 0);
        chk("hold_pop",  32'(o_stk_pop), 0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("hold_tos",   32'(o_tos), 30);
        chk("hold_depth", 32'(o_depth), 1);

        // reset during WAIT abandons the XOR
        do_reset();
        apply(0, 4, p, q, d, w);
        apply(0, 6, p, q, d, w);
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'd4;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("rstw_tos",   32'(o_tos), 0);
        chk("rstw_depth", 32'(o_depth), 0);
        chk("rstw_ready", 32'(o_ready), 1);
        chk("rstw_err",   32'(o_err), 0);

        // random ops against a queue-based model of the whole operand stack
        do_reset();
        m.delete();
        m_err  = 1'b0;
        m_code = 2'b00;
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  op;
            logic [17:0] imm, t, s, r, top;
            logic        un, ov, ep, eq;
            int          dd;
            op  = 3'($urandom_range(0, 7));
            imm = 18'($urandom);
            dd  = m.size();
            top = (dd > 0) ? m[dd-1] : '0;
            un = 1'b0; ov = 1'b0; ep = 1'b0; eq = 1'b0;
            case (op)
                3'd0: ov = (dd == 5);
                3'd5: begin un = (dd == 0); ov = (dd == 5); end
                3'd6: un = (dd == 0);
                default: un = (dd < 2);
            endcase
            if (un || ov) begin
                m_err = 1'b1;
                if (m_code == 2'b00) m_code = un ? 2'b01 : 2'b10;
            end else begin
                case (op)
                    3'd0: begin ep = (dd >= 1); m.push_back(imm); end
                    3'd5: begin ep = 1'b1; m.push_back(top); end
                    3'd6: begin eq = (dd >= 2); void'(m.pop_back()); end
                    3'd7: begin
                        ep = 1'b1; eq = 1'b1;
                        t = m.pop_back(); s = m.pop_back();
                        m.push_back(t); m.push_back(s);
                    end
                    default: begin
                        eq = 1'b1;
                        t = m.pop_back(); s = m.pop_back();
                        case (op)
                            3'd1: r = s + t;
                            3'd2: r = s - t;
                            3'd3: r = s & t;
                            default: r = s ^ t;
                        endcase
                        m.push_back(r);
                    end
                endcase
            end
            apply(op, imm, p, q, d, w);
            chk("rnd_push", 32'(p), 32'(ep));
            chk("rnd_pop",  32'(q), 32'(eq));
            if (ep) chk("rnd_data", 32'(d), 32'(top));
            chk("rnd_tos",   32'(o_tos), 32'((m.size() > 0) ? m[m.size()-1] : 18'd0));
            chk("rnd_depth", 32'(o_depth), 32'(m.size()));
            chk("rnd_err",   32'(o_err), 32'(m_err));
            chk("rnd_code",  32'(o_err_code), 32'(m_code));
            // occasionally clear errors and the stack so recovery paths get exercised
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
                m.delete();
                m_err  = 1'b0;
                m_code = 2'b00;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
